sm_target_feeder: RTL and testbench

//  Buffers target DNA sequences loaded as parallel words.

---
 rtl/sm_feeder_pkg.sv | 21 ++
 rtl/sm_target_feeder_if.sv | 34 +++
 rtl/sm_sync_fifo.sv | 46 ++++
 rtl/sm_target_feeder.sv | 131 +++++++++++++
 tb/tb_sm_target_feeder.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sm_feeder_pkg.sv
// rtl/sm_feeder_pkg.sv - shared base codes, default widths and load-entry layout for the target feeder
package sm_feeder_pkg;

  localparam logic [1:0] BASE_T = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_A = 2'b10;
  localparam logic [1:0] BASE_G = 2'b11;

  localparam int DEF_TARGET_LENGTH = 128;
  localparam int DEF_LEN_WIDTH     = 12;
  localparam int DEF_ID_WIDTH      = 48;
  localparam int DEF_FEED_DEPTH    = 2;
  localparam int DEF_ID_DEPTH      = 4;

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]        id;
    logic [DEF_LEN_WIDTH-1:0]       len;
    logic [2*DEF_TARGET_LENGTH-1:0] bases;
  } feed_entry_t;

endpackage

// File: rtl/sm_target_feeder_if.sv
// rtl/sm_target_feeder_if.sv - load/stream/ID bus between host loader, feeder and scoring array
// FEEDER_OVF_EN adds the sticky ovf signal.
interface sm_target_feeder_if
  import sm_feeder_pkg::*;
#(
  parameter int TARGET_LENGTH = DEF_TARGET_LENGTH,
  parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int ID_WIDTH      = DEF_ID_WIDTH
);
  logic                                     ld;
  logic                                     toggle;
  logic [ID_WIDTH+LEN_WIDTH+2*TARGET_LENGTH-1:0] feed_in;
  logic                                     re0;
  logic                                     re1;
  logic                                     en0;
  logic                                     en1;
  logic [1:0]                               data_out;
  logic                                     full;
  logic [ID_WIDTH-1:0]                      id0;
  logic [ID_WIDTH-1:0]                      id1;
`ifdef FEEDER_OVF_EN
  logic                                     ovf;

  modport master (output ld, toggle, feed_in, re0, re1,
                  input  en0, en1, data_out, full, id0, id1, ovf);
  modport slave  (input  ld, toggle, feed_in, re0, re1,
                  output en0, en1, data_out, full, id0, id1, ovf);
`else
  modport master (output ld, toggle, feed_in, re0, re1,
                  input  en0, en1, data_out, full, id0, id1);
  modport slave  (input  ld, toggle, feed_in, re0, re1,
                  output en0, en1, data_out, full, id0, id1);
`endif
endinterface

// File: rtl/sm_sync_fifo.sv
// rtl/sm_sync_fifo.sv - small synchronous FIFO with first-word-fall-through head
module sm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sm_target_feeder.sv
// rtl/sm_target_feeder.sv - buffers loaded targets and streams them base-by-base into two interleaved scoring channels
// Optional FEEDER_OVF_EN: sticky ovf on dropped loads or pops of an empty ID FIFO.
module sm_target_feeder
  import sm_feeder_pkg::*;
#(
  parameter int TARGET_LENGTH = DEF_TARGET_LENGTH,
  parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int ID_WIDTH      = DEF_ID_WIDTH,
  parameter int FEED_DEPTH    = DEF_FEED_DEPTH,
  parameter int ID_DEPTH      = DEF_ID_DEPTH
) (
  input logic               clk,
  input logic               rst,
  sm_target_feeder_if.slave bus
);
  localparam int BW = 2 * TARGET_LENGTH;
  localparam int EW = ID_WIDTH + LEN_WIDTH + BW;
  localparam int IW = $clog2(TARGET_LENGTH);

  logic [EW-1:0]        head;
  logic                 buf_full;
  logic                 buf_empty;
  logic                 buf_pop;
  logic [ID_WIDTH-1:0]  head_id;
  logic [LEN_WIDTH-1:0] head_len;
  logic [LEN_WIDTH-1:0] len_eff;
  logic [IW-1:0]        head_last;
  logic [BW-1:0]        head_bases;
  logic                 len_zero;

  logic                 take0;
  logic                 take1;
  logic [1:0]           load;
  logic [1:0]           active;
  logic [1:0]           en;
  logic [1:0]           data_q;
  logic [BW-1:0]        slot_bases [2];
  logic [IW-1:0]        slot_idx   [2];
  logic [IW-1:0]        slot_last  [2];

  logic [1:0]           idf_full;
  logic [1:0]           idf_empty;
  logic [ID_WIDTH-1:0]  idf_head [2];
  logic [1:0]           re_pop;

  sm_sync_fifo #(.WIDTH(EW), .DEPTH(FEED_DEPTH)) u_feed_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.ld),
    .pop   (buf_pop),
    .din   (bus.feed_in),
    .full  (buf_full),
    .empty (buf_empty),
    .head  (head)
  );

  assign head_id    = head[EW-1 -: ID_WIDTH];
  assign head_len   = head[BW +: LEN_WIDTH];
  assign head_bases = head[BW-1:0];
  assign len_zero   = (head_len == '0);
  assign len_eff    = (head_len > LEN_WIDTH'(TARGET_LENGTH)) ? LEN_WIDTH'(TARGET_LENGTH) : head_len;
  assign head_last  = IW'(len_eff - LEN_WIDTH'(1));

  // One pop per edge; channel 0 wins when both slots are free. Zero-length entries are popped and discarded.
  assign take0   = ~buf_empty & ~active[0] & ~idf_full[0];
  assign take1   = ~buf_empty & ~active[1] & ~idf_full[1] & ~take0;
  assign buf_pop = take0 | take1;
  assign load    = {take1, take0} & {2{~len_zero}};
  assign re_pop  = {bus.re1, bus.re0};

  for (genvar c = 0; c < 2; c++) begin : g_idf
    sm_sync_fifo #(.WIDTH(ID_WIDTH), .DEPTH(ID_DEPTH)) u_id_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (load[c]),
      .pop   (re_pop[c]),
      .din   (head_id),
      .full  (idf_full[c]),
      .empty (idf_empty[c]),
      .head  (idf_head[c])
    );
  end

  // A slot freed on its last base only reloads on a later edge, leaving the en gap that marks sequence end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= '0;
      en     <= '0;
      data_q <= '0;
      for (int c = 0; c < 2; c++) begin
        slot_bases[c] <= '0;
        slot_idx[c]   <= '0;
        slot_last[c]  <= '0;
      end
    end else begin
      en <= '0;
      for (int c = 0; c < 2; c++) begin
        if (load[c]) begin
          active[c]     <= 1'b1;
          slot_bases[c] <= head_bases;
          slot_idx[c]   <= '0;
          slot_last[c]  <= head_last;
        end
      end
      if (active[bus.toggle]) begin
        en[bus.toggle]       <= 1'b1;
        data_q               <= slot_bases[bus.toggle][{slot_idx[bus.toggle], 1'b0} +: 2];
        slot_idx[bus.toggle] <= slot_idx[bus.toggle] + IW'(1);
        if (slot_idx[bus.toggle] == slot_last[bus.toggle]) active[bus.toggle] <= 1'b0;
      end
    end
  end

  assign bus.en0      = en[0];
  assign bus.en1      = en[1];
  assign bus.data_out = data_q;
  assign bus.full     = buf_full;
  assign bus.id0      = idf_empty[0] ? '0 : idf_head[0];
  assign bus.id1      = idf_empty[1] ? '0 : idf_head[1];

`ifdef FEEDER_OVF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ovf <= 1'b0;
    end else if ((bus.ld && buf_full) || (bus.re0 && idf_empty[0]) || (bus.re1 && idf_empty[1])) begin
      bus.ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sm_target_feeder.sv
// tb/tb_sm_target_feeder.sv - directed scoreboard bench for sm_target_feeder
// Optional FEEDER_OVF_EN checks the sticky ovf output.
module tb_sm_target_feeder;
  import sm_feeder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm_target_feeder_if bus ();
  sm_target_feeder dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  logic [1:0]              q_base0 [$];
  logic [1:0]              q_base1 [$];
  logic [DEF_ID_WIDTH-1:0] q_id0 [$];
  logic [DEF_ID_WIDTH-1:0] q_id1 [$];
  logic alt = 1'b0;
  logic prev_en0 = 1'b0;
  int   rises0 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.en0) begin
      if (q_base0.size() == 0) chk("en0_unexpected", {63'd0, bus.en0}, 64'd0);
      else chk("data_ch0", {62'd0, bus.data_out}, {62'd0, q_base0.pop_front()});
    end
    if (bus.en1) begin
      if (q_base1.size() == 0) chk("en1_unexpected", {63'd0, bus.en1}, 64'd0);
      else chk("data_ch1", {62'd0, bus.data_out}, {62'd0, q_base1.pop_front()});
    end
    if (bus.en0 && !prev_en0) rises0++;
    prev_en0 = bus.en0;
    if (alt) bus.toggle = ~bus.toggle;
  endtask

  task automatic load(input logic [47:0] id, input logic [11:0] len, input logic [255:0] bases, input int ch);
    feed_entry_t e;
    int n;
    e.id = id;
    e.len = len;
    e.bases = bases;
    bus.feed_in = e;
    bus.ld = 1'b1;
    step();
    bus.ld = 1'b0;
    if (ch >= 0 && len != 0) begin
      n = (len > 12'd128) ? 128 : int'(len);
      for (int i = 0; i < n; i++) begin
        if (ch == 0) q_base0.push_back(bases[2*i +: 2]);
        else         q_base1.push_back(bases[2*i +: 2]);
      end
      if (ch == 0) q_id0.push_back(id);
      else         q_id1.push_back(id);
    end
  endtask

  task automatic drain(input string tag, input int which, input int budget);
    int n = 0;
    while (((which != 1 && q_base0.size() != 0) || (which != 0 && q_base1.size() != 0)) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(which == 1 ? q_base1.size() : (which == 0 ? q_base0.size() : q_base0.size() + q_base1.size())), 64'd0);
    repeat (4) step();
  endtask

  task automatic chk_ids(input string tag);
    chk({tag, "_id0"}, 64'(bus.id0), 64'(q_id0.size() != 0 ? q_id0[0] : 48'd0));
    chk({tag, "_id1"}, 64'(bus.id1), 64'(q_id1.size() != 0 ? q_id1[0] : 48'd0));
  endtask

  task automatic pop_id(input int ch, input string tag);
    if (ch == 0) bus.re0 = 1'b1; else bus.re1 = 1'b1;
    step();
    bus.re0 = 1'b0;
    bus.re1 = 1'b0;
    if (ch == 0 && q_id0.size() != 0) void'(q_id0.pop_front());
    if (ch == 1 && q_id1.size() != 0) void'(q_id1.pop_front());
    chk_ids(tag);
  endtask

  initial begin
    logic [255:0] seq_a;
    logic [255:0] acgt;
    bus.ld = 1'b0;
    bus.toggle = 1'b0;
    bus.re0 = 1'b0;
    bus.re1 = 1'b0;
    bus.feed_in = '0;
    rst = 1'b1;
    #1 rst = 1'b0;

    // 1: reset held with ld asserted
    bus.ld = 1'b1;
    bus.feed_in = {48'd9, 12'd4, 256'hFF};
    repeat (3) step();
    chk("rst_en0", 64'(bus.en0), 64'd0);
    chk("rst_en1", 64'(bus.en1), 64'd0);
    chk("rst_data", 64'(bus.data_out), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk_ids("rst");
    bus.ld = 1'b0;
    rst = 1'b1;
    step();
    chk("post_rst_full", 64'(bus.full), 64'd0);
    chk("post_rst_en0", 64'(bus.en0), 64'd0);
    chk("post_rst_en1", 64'(bus.en1), 64'd0);

    // 2: ACGT on channel 0
    acgt = '0;
    acgt[7:0] = {BASE_T, BASE_G, BASE_C, BASE_A};
    rises0 = 0;
    load(48'd5, 12'd4, acgt, 0);
    drain("t2_drain", 0, 20);
    chk("t2_runs", 64'(rises0), 64'd1);
    chk_ids("t2");
    pop_id(0, "t2_pop");

    // 3: alternating toggle, two sequences interleaved
    alt = 1'b1;
    load(48'd0, 12'd3, 256'h1B, 0);
    load(48'd1, 12'd3, 256'h0E, 1);
    drain("t3_drain", 2, 30);
    alt = 1'b0;
    bus.toggle = 1'b0;
    chk_ids("t3");
    pop_id(0, "t3_pop0");
    pop_id(1, "t3_pop1");
`ifdef FEEDER_OVF_EN
    chk("t3_ovf", 64'(bus.ovf), 64'd0);
`endif

    // 4: stalled scoring side fills the buffer; overlong len clamps
    for (int i = 0; i < 8; i++) seq_a[32*i +: 32] = $urandom;
    load(48'hA, 12'd200, seq_a, 0);
    load(48'hB, 12'd4, 256'hC6, 1);
    load(48'hC, 12'd3, 256'h2D, 0);
    chk("t4_full_c", 64'(bus.full), 64'd0);
    load(48'hD, 12'd2, 256'h9, 0);
    chk("t4_full_d", 64'(bus.full), 64'd1);
    load(48'hE, 12'd5, 256'h3FF, -1);
    chk("t4_full_e", 64'(bus.full), 64'd1);
`ifdef FEEDER_OVF_EN
    chk("t4_ovf", 64'(bus.ovf), 64'd1);
`endif
    drain("t4_drain0", 0, 400);
    chk("t4_full_end", 64'(bus.full), 64'd0);
    bus.toggle = 1'b1;
    drain("t4_drain1", 1, 20);
    bus.toggle = 1'b0;
    chk_ids("t4");
    pop_id(0, "t4_pop0a");
    pop_id(0, "t4_pop0b");
    pop_id(0, "t4_pop0c");
    pop_id(1, "t4_pop1");

    // 5: zero-length entry is discarded
    load(48'd77, 12'd0, 256'hFF, -1);
    load(48'd88, 12'd2, 256'h6, 0);
    drain("t5_drain", 0, 20);
    chk_ids("t5");
    pop_id(0, "t5_pop");
    pop_id(0, "t5_pop_empty");

    // 6: back-to-back on channel 0 while channel 1 holds a stalled slot
    rises0 = 0;
    load(48'h61, 12'd2, 256'hB, 0);
    load(48'h62, 12'd3, 256'h24, 1);
    load(48'h63, 12'd2, 256'h7, 0);
    drain("t6_drain0", 0, 30);
    chk("t6_runs", 64'(rises0), 64'd2);
    bus.toggle = 1'b1;
    drain("t6_drain1", 1, 20);
    bus.toggle = 1'b0;
    chk_ids("t6");
    pop_id(0, "t6_pop0a");
    pop_id(0, "t6_pop0b");
    pop_id(1, "t6_pop1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
